// File: rtl/act_loader_pkg.sv
// Shared constants and FSM state type for the activation buffer fill stage.
package act_loader_pkg;

    localparam int IF_WIDTH        = 16;                 // lanes per row, flag width
    localparam int DATA_WIDTH      = 8;                  // activation / stream byte width
    localparam int ROW_CNT_W       = 10;                 // row counter width
    localparam int ACT_INDEX_WIDTH = $clog2(IF_WIDTH);   // lane index width

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLAG_LO,
        ST_FLAG_HI,
        ST_DATA,
        ST_DONE
    } state_e;

endpackage

// File: rtl/act_loader_lsb_index.sv
// Lowest-set-bit encoder: index of the least significant 1 in vec, plus an 'any' flag.
module act_loader_lsb_index
    import act_loader_pkg::*;
(
    input  logic [IF_WIDTH-1:0]        vec,
    output logic [ACT_INDEX_WIDTH-1:0] idx,
    output logic                       any
);

    // Scan from the top down so the last hit written is the lowest set bit.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        idx = '0;
        for (int i = IF_WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) idx = ACT_INDEX_WIDTH'(i);
        end
    end

    assign any = |vec;

endmodule

// File: rtl/act_loader.sv
// Activation loader: unpacks a flag-compressed byte stream into flag RAM and per-lane column RAM writes.
module act_loader
    import act_loader_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [ROW_CNT_W-1:0]           cfg_rows,
    input  logic                           in_valid,
    input  logic [DATA_WIDTH-1:0]          in_data,
    output logic                           in_ready,
    input  logic                           buf_full,
    output logic                           wr_req_act_flag,
    output logic [IF_WIDTH-1:0]            wr_data_act_flag,
    output logic [IF_WIDTH-1:0]            wr_req_act,
    output logic [IF_WIDTH*DATA_WIDTH-1:0] wr_data_act,
    output logic                           busy,
    output logic                           done,
    output logic [ROW_CNT_W-1:0]           rows_loaded
);

    state_e                         state_q, state_d;
    logic [DATA_WIDTH-1:0]          flag_lo_q, flag_lo_d;
    logic [IF_WIDTH-1:0]            mask_q, mask_d;
    logic [ROW_CNT_W-1:0]           rows_cfg_q, rows_cfg_d;
    logic [ROW_CNT_W-1:0]           rows_loaded_q, rows_loaded_d;
    logic                           flag_wr_q, flag_wr_d;
    logic [IF_WIDTH-1:0]            flag_word_q, flag_word_d;
    logic [IF_WIDTH-1:0]            lane_wr_q, lane_wr_d;
    logic [IF_WIDTH*DATA_WIDTH-1:0] lane_data_q, lane_data_d;

    logic [ACT_INDEX_WIDTH-1:0]     lane_idx;
    logic                           lane_any;
    logic [IF_WIDTH-1:0]            lane_onehot;
    logic [IF_WIDTH-1:0]            mask_left;
    logic [IF_WIDTH-1:0]            flag_word;
    logic [ROW_CNT_W-1:0]           rows_inc;
    logic                           last_row;
    logic                           accept;
    logic                           strobe_pending;

    act_loader_lsb_index u_lsb_index (
        .vec (mask_q),
        .idx (lane_idx),
        .any (lane_any)
    );

    assign in_ready       = (state_q inside {ST_FLAG_LO, ST_FLAG_HI, ST_DATA}) && !buf_full;
    assign accept         = in_valid && in_ready;
    assign flag_word      = {in_data, flag_lo_q};
    assign lane_onehot    = IF_WIDTH'(1) << lane_idx;
    assign mask_left      = mask_q & ~lane_onehot;
    assign rows_inc       = rows_loaded_q + ROW_CNT_W'(1);
    assign last_row       = (rows_inc == rows_cfg_q);
    // The final row's strobe is still in flight on entry to DONE; done waits for it to retire.
    assign strobe_pending = flag_wr_q || (|lane_wr_q);
    assign done           = (state_q == ST_DONE) && !strobe_pending;
    assign busy           = (state_q != ST_IDLE) && !done;

    assign wr_req_act_flag  = flag_wr_q;
    assign wr_data_act_flag = flag_word_q;
    assign wr_req_act       = lane_wr_q;
    assign wr_data_act      = lane_data_q;
    assign rows_loaded      = rows_loaded_q;

    // Next-state, unpack and write-port logic; strobes default low so each lasts one cycle.
    always_comb begin
        state_d       = state_q;
        flag_lo_d     = flag_lo_q;
        mask_d        = mask_q;
        rows_cfg_d    = rows_cfg_q;
        rows_loaded_d = rows_loaded_q;
        flag_wr_d     = 1'b0;
        flag_word_d   = flag_word_q;
        lane_wr_d     = '0;
        lane_data_d   = lane_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rows_cfg_d    = cfg_rows;
                    rows_loaded_d = '0;
                    state_d       = (cfg_rows == '0) ? ST_DONE : ST_FLAG_LO;
                end
            end
            ST_FLAG_LO: begin
                if (accept) begin
                    flag_lo_d = in_data;
                    state_d   = ST_FLAG_HI;
                end
            end
            ST_FLAG_HI: begin
                if (accept) begin
                    mask_d      = flag_word;
                    flag_wr_d   = 1'b1;
                    flag_word_d = flag_word;
                    if (flag_word == '0) begin
                        rows_loaded_d = rows_inc;
                        state_d       = last_row ? ST_DONE : ST_FLAG_LO;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept && lane_any) begin
                    mask_d    = mask_left;
                    lane_wr_d = lane_onehot;
                    lane_data_d[lane_idx*DATA_WIDTH +: DATA_WIDTH] = in_data;
                    if (mask_left == '0) begin
                        rows_loaded_d = rows_inc;
                        state_d       = last_row ? ST_DONE : ST_FLAG_LO;
                    end
                end
            end
            ST_DONE: begin
                if (!strobe_pending) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; all clear so a reset mid-load leaves no stale strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            flag_lo_q     <= '0;
            mask_q        <= '0;
            rows_cfg_q    <= '0;
            rows_loaded_q <= '0;
            flag_wr_q     <= 1'b0;
            flag_word_q   <= '0;
            lane_wr_q     <= '0;
            lane_data_q   <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge values.
            state_q       <= state_d;
            flag_lo_q     <= flag_lo_d;
            mask_q        <= mask_d;
            rows_cfg_q    <= rows_cfg_d;
            rows_loaded_q <= rows_loaded_d;
            flag_wr_q     <= flag_wr_d;
            flag_word_q   <= flag_word_d;
            lane_wr_q     <= lane_wr_d;
            lane_data_q   <= lane_data_d;
        end
    end

endmodule

// File: tb/tb_act_loader.sv
// Scoreboard bench for act_loader: expected writes are queued as bytes are driven, popped on strobes.
module tb_act_loader;
    import act_loader_pkg::*;

    logic                           clk = 1'b0;
    logic                           reset = 1'b1;
    logic                           start = 1'b0;
    logic [ROW_CNT_W-1:0]           cfg_rows = '0;
    logic                           in_valid = 1'b0;
    logic [DATA_WIDTH-1:0]          in_data = '0;
    logic                           in_ready;
    logic                           buf_full = 1'b0;
    logic                           wr_req_act_flag;
    logic [IF_WIDTH-1:0]            wr_data_act_flag;
    logic [IF_WIDTH-1:0]            wr_req_act;
    logic [IF_WIDTH*DATA_WIDTH-1:0] wr_data_act;
    logic                           busy;
    logic                           done;
    logic [ROW_CNT_W-1:0]           rows_loaded;

    act_loader dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .cfg_rows         (cfg_rows),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .buf_full         (buf_full),
        .wr_req_act_flag  (wr_req_act_flag),
        .wr_data_act_flag (wr_data_act_flag),
        .wr_req_act       (wr_req_act),
        .wr_data_act      (wr_data_act),
        .busy             (busy),
        .done             (done),
        .rows_loaded      (rows_loaded)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        bit          is_flag;
        int          lane;
        logic [15:0] req;
        logic [15:0] data;
    } exp_t;

    exp_t                           sb_q[$];
    logic [IF_WIDTH*DATA_WIDTH-1:0] exp_bus = '0;
    int n_total = 0;
    int n_bad   = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_strobe_cyc = 0;
    int strobe_cycs[$];
    int full_viol = 0;
    bit bf_en = 1'b0;
    int bf_cnt = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // buf_full pattern: high one cycle in three while enabled.
    initial forever begin
        @(negedge clk);
        if (bf_en) begin
            bf_cnt++;
            buf_full = (bf_cnt % 3 == 0);
        end else begin
            buf_full = 1'b0;
        end
    end

    // Monitor: pops the scoreboard on every strobe and counts done pulses.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!reset) begin
            if (wr_req_act_flag || (wr_req_act != '0)) begin
                last_strobe_cyc = cyc;
                strobe_cycs.push_back(cyc);
                if (sb_q.size() == 0) begin
                    check("unexpected_strobe", {wr_req_act_flag, wr_req_act}, 17'h0);
                end else begin
                    e = sb_q.pop_front();
                    if (e.is_flag) begin
                        check("flag_strobe", {wr_req_act_flag, wr_req_act}, {1'b1, 16'h0});
                        check("flag_data", wr_data_act_flag, e.data);
                    end else begin
                        check("lane_strobe", {wr_req_act_flag, wr_req_act}, {1'b0, e.req});
                        exp_bus[e.lane*DATA_WIDTH +: DATA_WIDTH] = e.data[7:0];
                        check("lane_data", wr_data_act, exp_bus);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        #1;
        if (buf_full && in_ready) full_viol++;
        while (!in_ready) begin
            waited++;
            if (waited > 500) begin
                check("accept_timeout", waited, 0);
                break;
            end
            @(negedge clk);
            #1;
            if (buf_full && in_ready) full_viol++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic gap(input int max_gap);
        if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
    endtask

    task automatic send_row(input logic [15:0] flag, input bit rnd, input int max_gap);
        exp_t e;
        int k = 0;
        logic [7:0] b;
        gap(max_gap);
        send_byte(flag[7:0]);
        e.is_flag = 1'b1; e.lane = 0; e.req = '0; e.data = flag;
        sb_q.push_back(e);
        gap(max_gap);
        send_byte(flag[15:8]);
        for (int i = 0; i < 16; i++) begin
            if (flag[i]) begin
                b = rnd ? 8'($urandom_range(1, 255)) : 8'(8'h11 * (k + 1));
                k++;
                e.is_flag = 1'b0; e.lane = i; e.req = 16'h1 << i; e.data = {8'h00, b};
                sb_q.push_back(e);
                gap(max_gap);
                send_byte(b);
            end
        end
    endtask

    task automatic do_start(input int n);
        @(negedge clk);
        start    = 1'b1;
        cfg_rows = ROW_CNT_W'(n);
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(input int base);
        int w = 0;
        while (done_cnt == base) begin
            @(negedge clk);
            #1;
            w++;
            if (w > 2000) begin
                check("done_timeout", done_cnt, base + 1);
                break;
            end
        end
    endtask

    initial begin
        int base;
        int seen_ready;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", in_ready, 0);
        check("rst_strobes", {wr_req_act_flag, wr_req_act}, 17'h0);
        check("rst_rows", rows_loaded, 0);
        @(negedge clk);
        reset = 1'b0;

        // Single row, flag 0x8005, back-to-back bytes
        base = done_cnt;
        strobe_cycs.delete();
        do_start(1);
        send_row(16'h8005, 1'b0, 0);
        wait_done(base);
        check("t2_strobe_span", strobe_cycs[$] - strobe_cycs[0], 3);
        check("t2_done_lat", done_cyc - last_strobe_cyc, 1);
        check("t2_rows", rows_loaded, 1);
        check("t2_busy", busy, 0);

        // Reset in the middle of DATA
        do_start(2);
        send_row(16'h0000, 1'b0, 0);
        send_byte(8'h03);
        send_byte(8'h00);
        begin
            exp_t e;
            e.is_flag = 1'b1; e.lane = 0; e.req = '0; e.data = 16'h0003;
            sb_q.push_back(e);
            e.is_flag = 1'b0; e.lane = 0; e.req = 16'h0001; e.data = 16'h00AA;
            sb_q.push_back(e);
        end
        send_byte(8'hAA);
        @(negedge clk);
        #1;
        reset = 1'b1;
        sb_q.delete();
        exp_bus = '0;
        repeat (2) begin
            @(negedge clk);
            #1;
            check("t1_busy_in_rst", busy, 0);
            check("t1_strobes_in_rst", {wr_req_act_flag, wr_req_act}, 17'h0);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("t1_busy_after", busy, 0);
        check("t1_rows_after", rows_loaded, 0);
        check("t1_bus_after", wr_data_act, 0);

        // Three empty rows
        base = done_cnt;
        do_start(3);
        repeat (3) send_row(16'h0000, 1'b0, 0);
        wait_done(base);
        check("t3_rows", rows_loaded, 3);
        check("t3_sb_drain", sb_q.size(), 0);

        // Full row with periodic buf_full back-pressure
        base = done_cnt;
        full_viol = 0;
        bf_en = 1'b1;
        do_start(1);
        send_row(16'hFFFF, 1'b0, 0);
        wait_done(base);
        bf_en = 1'b0;
        check("t4_ready_while_full", full_viol, 0);
        check("t4_rows", rows_loaded, 1);
        check("t4_sb_drain", sb_q.size(), 0);

        // cfg_rows = 0, then start while busy
        base = done_cnt;
        do_start(0);
        #1;
        check("t5_done_pulse", done, 1);
        check("t5_done_cnt", done_cnt, base + 1);
        seen_ready = in_ready ? 1 : 0;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (in_ready) seen_ready++;
        end
        in_valid = 1'b0;
        check("t5_ready_never", seen_ready, 0);
        check("t5_done_single", done_cnt, base + 1);
        check("t5_rows_zero", rows_loaded, 0);
        base = done_cnt;
        do_start(1);
        do_start(5);
        send_row(16'h0010, 1'b1, 0);
        wait_done(base);
        check("t5_ignored_start", rows_loaded, 1);
        repeat (4) @(negedge clk);
        #1;
        check("t5_single_done", done_cnt, base + 1);
        check("t5_rows_hold", rows_loaded, 1);

        // Random rows with gapped in_valid
        base = done_cnt;
        do_start(8);
        for (int r = 0; r < 8; r++) send_row(16'($urandom), 1'b1, 2);
        wait_done(base);
        check("t6_rows", rows_loaded, 8);
        check("t6_sb_drain", sb_q.size(), 0);
        check("final_ready_full", full_viol, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
